// File: rtl/rom_stream_reader.sv
// ============================================================================
// rom_stream_reader : ROM burst address sequencer with valid/ready stream out
// Revision 1.0
// ============================================================================
`default_nettype none

module rom_stream_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   remaining;
  logic              slot_free;

  assign slot_free = !m_valid || m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rom_addr  <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            checksum <= '0;
            if (length != '0) begin
              rom_addr  <= start_addr;
              remaining <= length;
              busy      <= 1'b1;
              state     <= READ;
            end else begin
              // Empty burst completes immediately without ever going busy
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (slot_free) begin
            m_data    <= rom_data;
            m_valid   <= 1'b1;
            checksum  <= checksum + rom_data;
            rom_addr  <= rom_addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Final word is loaded; wait for it to be accepted
          if (m_ready) begin
            m_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
